uart_ans_timeout_ctrl: RTL and testbench
========================================

# uart_ans_timeout_ctrl

Transaction sequencer for the UART answer path. It launches one frame on the tx core, waits for tx completion, then times the slave's answer against a programmable limit in 0.1 ms ticks. On timeout it re-sends up to a programmable retry count, then reports the final outcome to the host. It sits between the host register interface, the tx core and the rx core, alongside the answer-delay measurement logic, and uses the same tx-finished and rx-received pulses.

## Interface
Parameters:
- CNT_W, 16: width of the tick counter, timeout limit and elapsed result.
- RTY_W, 3: width of the retry limit and retry counter.

Ports:
- clk  in  1  system clock, ≥40 MHz.
- rst  in  1  reset, asynchronous, active-low; released synchronously to clk.
- p_start_i  in  1  one-cycle request to start a transaction; ignored while busy_o=1.
- p_abort_i  in  1  one-cycle abort; returns to IDLE from any state.
- timeout_limit_i  in  CNT_W  answer limit in ticks; sampled when p_start_i is accepted.
- retry_max_i  in  RTY_W  number of re-sends allowed; sampled when p_start_i is accepted.
- p_tick_i  in  1  one-cycle 0.1 ms time-base pulse.
- p_SendFinished_i  in  1  tx core pulse: stop bit of the last byte has been sent.
- p_DataReceived_i  in  1  rx core pulse: first answer byte detected.
- p_tx_req_o  out  1  one-cycle pulse to the tx core to (re)send the frame.
- busy_o  out  1  transaction in progress.
- p_done_o  out  1  one-cycle pulse: answer received.
- p_timeout_o  out  1  one-cycle pulse: all retries exhausted without an answer.
- retry_cnt_o  out  RTY_W  number of re-sends performed in the current or last transaction.
- elapsed_o  out  CNT_W  tick count of the final attempt, latched when the transaction ends.

## Operation
- States: IDLE, SEND, WAIT_TX, WAIT_ANS. All outputs are registered.
- IDLE:
  - p_start_i → SEND.
  - Latch limit_r and rmax_r from the inputs; clear retry_cnt_o.
- SEND: p_tx_req_o=1 for exactly one cycle, then → WAIT_TX.
- WAIT_TX:
  - p_SendFinished_i → WAIT_ANS and clear cnt_r.
  - p_DataReceived_i is ignored in this state (it is the echo or stale data of the frame in flight).
  - p_tick_i is ignored in this state.
- WAIT_ANS:
  - cnt_r increments on each p_tick_i and saturates at all-ones.
  - Timeout condition: cnt_r ≥ limit_r. With limit 0, timeout occurs on the first cycle in WAIT_ANS.
  - p_DataReceived_i → IDLE; p_done_o pulses; elapsed_o ← cnt_r.
  - If timeout and retry_cnt_o < rmax_r: retry_cnt_o += 1, → SEND.
  - If timeout and retry_cnt_o = rmax_r: → IDLE; p_timeout_o pulses; elapsed_o ← cnt_r.
- Simultaneous events:
  - p_DataReceived_i and timeout in the same cycle: the answer wins (done, no retry).
  - p_tick_i in the same cycle as the timeout-exit edge is dropped.
- p_abort_i:
  - Highest priority in every state: → IDLE, no p_done_o or p_timeout_o pulse.
  - elapsed_o and retry_cnt_o hold their values.
  - p_start_i in the same cycle as p_abort_i is ignored.
- p_start_i while busy_o=1 is ignored. limit_r and rmax_r do not change mid-transaction.
- Reset values:
  - State IDLE; cnt_r=0.
  - p_tx_req_o, busy_o, p_done_o and p_timeout_o = 0.
  - retry_cnt_o=0, elapsed_o=0, limit_r=0, rmax_r=0.
- Reset asserted mid-transaction: everything returns to the reset values immediately; no pulses are emitted.

## Timing
- p_start_i sampled at edge N: busy_o=1 and p_tx_req_o=1 from edge N+1; p_tx_req_o falls at N+2.
- p_SendFinished_i sampled at edge M in WAIT_TX: WAIT_ANS from M+1 with cnt_r=0.
- Tick at edge T in WAIT_ANS: cnt_r updated at T+1.
- Timeout detected at edge K:
  - Retry case: p_tx_req_o high at K+1.
  - Final case: p_timeout_o high at K+1, busy_o low at K+1.
- p_DataReceived_i at edge R: p_done_o high at R+1, busy_o low at R+1, elapsed_o valid at R+1.
- Earliest restart: p_start_i can be accepted in the same cycle that p_done_o or p_timeout_o is high.

## Test plan
- Answer case: limit=10, rmax=2; start; SendFinished; 4 ticks; DataReceived → one p_tx_req_o, p_done_o, elapsed_o=4, retry_cnt_o=0.
- Timeout with retries: limit=3, rmax=2; no answer (each attempt gets SendFinished, then 3 ticks) → three p_tx_req_o pulses, then p_timeout_o, retry_cnt_o=2, elapsed_o=3.
- Answer on retry: limit=3, rmax=1; first attempt times out; on the second attempt DataReceived after 1 tick → p_done_o, retry_cnt_o=1, elapsed_o=1.
- Race, same cycle: DataReceived in the same cycle that cnt_r reaches limit (limit=2) → p_done_o, no extra p_tx_req_o. Separately, DataReceived in WAIT_TX → ignored; state stays WAIT_TX.
- Edge limits: limit=0, rmax=0 → p_timeout_o one cycle after entering WAIT_ANS, elapsed_o=0. With limit=16'hFFFF, 70000 ticks → cnt_r saturates at FFFF, then times out.
- Abort, start-while-busy and reset: p_abort_i in WAIT_ANS → busy_o=0, no pulse. p_start_i while busy → no second p_tx_req_o. rst low in WAIT_TX → all outputs 0 immediately.

Source files
------------

// File: rtl/uart_ans_timeout_ctrl.sv
// Answer-path transaction sequencer: sends a frame, times the slave's answer in
// ticks, re-sends on timeout up to a retry limit, and reports done/timeout.
module uart_ans_timeout_ctrl #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned RTY_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             p_start_i,
  input  logic             p_abort_i,
  input  logic [CNT_W-1:0] timeout_limit_i,
  input  logic [RTY_W-1:0] retry_max_i,
  input  logic             p_tick_i,
  input  logic             p_SendFinished_i,
  input  logic             p_DataReceived_i,
  output logic             p_tx_req_o,
  output logic             busy_o,
  output logic             p_done_o,
  output logic             p_timeout_o,
  output logic [RTY_W-1:0] retry_cnt_o,
  output logic [CNT_W-1:0] elapsed_o
);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_TX,
    WAIT_ANS
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] limit_q, limit_d;
  logic [CNT_W-1:0] elapsed_q, elapsed_d;
  logic [RTY_W-1:0] rmax_q, rmax_d;
  logic [RTY_W-1:0] retry_q, retry_d;
  logic             tx_req_q, tx_req_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             to_q, to_d;
  logic             timeout;

  assign timeout = (cnt_q >= limit_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    limit_d   = limit_q;
    rmax_d    = rmax_q;
    retry_d   = retry_q;
    elapsed_d = elapsed_q;
    tx_req_d  = 1'b0;
    done_d    = 1'b0;
    to_d      = 1'b0;

    if (p_abort_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (p_start_i) begin
            state_d  = SEND;
            limit_d  = timeout_limit_i;
            rmax_d   = retry_max_i;
            retry_d  = '0;
            tx_req_d = 1'b1;
          end
        end
        SEND: state_d = WAIT_TX;
        WAIT_TX: begin
          // Rx pulses here are the echo of the frame still in flight.
          if (p_SendFinished_i) begin
            state_d = WAIT_ANS;
            cnt_d   = '0;
          end
        end
        WAIT_ANS: begin
          // Answer beats a coincident timeout; a tick on any exit edge is dropped.
          if (p_DataReceived_i) begin
            state_d   = IDLE;
            done_d    = 1'b1;
            elapsed_d = cnt_q;
          end else if (timeout) begin
            if (retry_q < rmax_q) begin
              state_d  = SEND;
              retry_d  = retry_q + RTY_W'(1);
              tx_req_d = 1'b1;
            end else begin
              state_d   = IDLE;
              to_d      = 1'b1;
              elapsed_d = cnt_q;
            end
          end else if (p_tick_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      limit_q   <= '0;
      rmax_q    <= '0;
      retry_q   <= '0;
      elapsed_q <= '0;
      tx_req_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      to_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      limit_q   <= limit_d;
      rmax_q    <= rmax_d;
      retry_q   <= retry_d;
      elapsed_q <= elapsed_d;
      tx_req_q  <= tx_req_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      to_q      <= to_d;
    end
  end

  assign p_tx_req_o  = tx_req_q;
  assign busy_o      = busy_q;
  assign p_done_o    = done_q;
  assign p_timeout_o = to_q;
  assign retry_cnt_o = retry_q;
  assign elapsed_o   = elapsed_q;

endmodule

// File: tb/tb_uart_ans_timeout_ctrl.sv
// Bench for uart_ans_timeout_ctrl: transaction-level outcome model
// (attempt count, done vs timeout, elapsed ticks) plus directed corner cases.
module tb_uart_ans_timeout_ctrl;
  localparam int CNT_W = 16;
  localparam int RTY_W = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             p_start_i = 1'b0;
  logic             p_abort_i = 1'b0;
  logic [CNT_W-1:0] timeout_limit_i = '0;
  logic [RTY_W-1:0] retry_max_i = '0;
  logic             p_tick_i = 1'b0;
  logic             p_SendFinished_i = 1'b0;
  logic             p_DataReceived_i = 1'b0;
  logic             p_tx_req_o, busy_o, p_done_o, p_timeout_o;
  logic [RTY_W-1:0] retry_cnt_o;
  logic [CNT_W-1:0] elapsed_o;

  int checks = 0;
  int errors = 0;
  int n_tx = 0, n_done = 0, n_to = 0;
  int last_elapsed = 0;

  uart_ans_timeout_ctrl #(.CNT_W(CNT_W), .RTY_W(RTY_W)) dut (
    .clk(clk), .rst(rst),
    .p_start_i(p_start_i), .p_abort_i(p_abort_i),
    .timeout_limit_i(timeout_limit_i), .retry_max_i(retry_max_i),
    .p_tick_i(p_tick_i), .p_SendFinished_i(p_SendFinished_i),
    .p_DataReceived_i(p_DataReceived_i),
    .p_tx_req_o(p_tx_req_o), .busy_o(busy_o), .p_done_o(p_done_o),
    .p_timeout_o(p_timeout_o), .retry_cnt_o(retry_cnt_o), .elapsed_o(elapsed_o)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      if (p_tx_req_o)  n_tx++;
      if (p_done_o)    n_done++;
      if (p_timeout_o) n_to++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) cyc();
    checks++;
    if ({p_tx_req_o, busy_o, p_done_o, p_timeout_o} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b expected 0000", {p_tx_req_o, busy_o, p_done_o, p_timeout_o});
    end
    checks++;
    if (retry_cnt_o !== '0 || elapsed_o !== '0) begin
      errors++; $display("FAIL reset_values: got retry=%0d elapsed=%0d expected 0/0", retry_cnt_o, elapsed_o);
    end
    rst = 1'b1;
    repeat (2) cyc();
  endtask

  // One full transaction. The slave answers on attempt ans_att after ans_ticks
  // ticks (ans_ticks <= limit); ans_att > rmax means it never answers.
  task automatic run_txn(input int limit, input int rmax, input int ans_att,
                         input int ans_ticks, input bit noise);
    int  attempts, tx0, d0, t0, exp_el;
    bit  answered, ok;
    answered = (ans_att <= rmax);
    attempts = answered ? ans_att + 1 : rmax + 1;
    exp_el   = answered ? ans_ticks : limit;
    tx0 = n_tx; d0 = n_done; t0 = n_to;

    timeout_limit_i = CNT_W'(limit);
    retry_max_i     = RTY_W'(rmax);
    p_start_i = 1'b1; cyc(); p_start_i = 1'b0;
    timeout_limit_i = CNT_W'($urandom);
    retry_max_i     = RTY_W'($urandom);
    checks++;
    if (busy_o !== 1'b1) begin
      errors++; $display("FAIL start_busy: got %b expected 1", busy_o);
    end

    for (int a = 0; a < attempts; a++) begin
      ok = 1'b0;
      for (int w = 0; w < 4 && !ok; w++) begin
        if (p_tx_req_o === 1'b1) ok = 1'b1;
        else cyc();
      end
      checks++;
      if (!ok) begin
        errors++; $display("FAIL tx_req_wait: got no pulse expected pulse on attempt %0d", a);
        p_abort_i = 1'b1; cyc(); p_abort_i = 1'b0;
        return;
      end
      cyc();
      if (noise) begin
        repeat ($urandom_range(0, 3)) begin
          p_DataReceived_i = 1'($urandom);
          p_tick_i = 1'($urandom);
          cyc();
        end
        p_DataReceived_i = 1'b0;
        p_tick_i = 1'b0;
      end
      p_SendFinished_i = 1'b1; cyc(); p_SendFinished_i = 1'b0;
      if (answered && a == ans_att) begin
        for (int k = 0; k < ans_ticks; k++) begin
          repeat ($urandom_range(0, 2)) cyc();
          p_tick_i = 1'b1; cyc(); p_tick_i = 1'b0;
        end
        p_DataReceived_i = 1'b1;
        p_tick_i = 1'($urandom);
        cyc();
        p_DataReceived_i = 1'b0;
        p_tick_i = 1'b0;
      end else begin
        for (int k = 0; k < limit; k++) begin
          repeat ($urandom_range(0, 2)) cyc();
          p_tick_i = 1'b1; cyc(); p_tick_i = 1'b0;
        end
        p_tick_i = 1'b1; cyc(); p_tick_i = 1'b0;
      end
    end

    checks++;
    if (p_done_o !== answered || p_timeout_o !== !answered || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL outcome: got done=%b timeout=%b busy=%b expected done=%b timeout=%b busy=0 (limit=%0d rmax=%0d)",
               p_done_o, p_timeout_o, busy_o, answered, !answered, limit, rmax);
    end
    checks++;
    if (retry_cnt_o !== RTY_W'(attempts - 1)) begin
      errors++; $display("FAIL retry_cnt: got %0d expected %0d", retry_cnt_o, attempts - 1);
    end
    checks++;
    if (elapsed_o !== CNT_W'(exp_el)) begin
      errors++; $display("FAIL elapsed: got %0d expected %0d", elapsed_o, exp_el);
    end
    cyc();
    checks++;
    if (n_tx - tx0 != attempts || n_done - d0 != int'(answered) || n_to - t0 != int'(!answered)) begin
      errors++;
      $display("FAIL pulse_count: got tx=%0d done=%0d to=%0d expected tx=%0d done=%0d to=%0d",
               n_tx - tx0, n_done - d0, n_to - t0, attempts, answered, !answered);
    end
    last_elapsed = exp_el;
  endtask

  task automatic test_directed();
    run_txn(10, 2, 0, 4, 1'b0);
    run_txn(3, 2, 3, 0, 1'b0);
    run_txn(3, 1, 1, 1, 1'b0);
    run_txn(2, 1, 0, 2, 1'b0);
    run_txn(0, 0, 1, 0, 1'b0);
    run_txn(0, 2, 1, 0, 1'b1);
  endtask

  task automatic test_random();
    int lim, rm, aa, at;
    for (int i = 0; i < 25; i++) begin
      lim = $urandom_range(0, 12);
      rm  = $urandom_range(0, 3);
      aa  = $urandom_range(0, rm + 1);
      at  = $urandom_range(0, lim);
      run_txn(lim, rm, aa, at, 1'b1);
    end
  endtask

  task automatic test_start_while_busy();
    int tx0;
    tx0 = n_tx;
    timeout_limit_i = CNT_W'(3); retry_max_i = '0;
    p_start_i = 1'b1; cyc(); p_start_i = 1'b0;
    checks++;
    if (p_tx_req_o !== 1'b1) begin
      errors++; $display("FAIL tx_req_rise: got %b expected 1", p_tx_req_o);
    end
    cyc();
    checks++;
    if (p_tx_req_o !== 1'b0 || busy_o !== 1'b1) begin
      errors++; $display("FAIL tx_req_fall: got tx=%b busy=%b expected tx=0 busy=1", p_tx_req_o, busy_o);
    end
    timeout_limit_i = CNT_W'(9); retry_max_i = RTY_W'(5);
    p_start_i = 1'b1; cyc(); p_start_i = 1'b0;
    p_SendFinished_i = 1'b1; cyc(); p_SendFinished_i = 1'b0;
    p_start_i = 1'b1;
    repeat (3) begin p_tick_i = 1'b1; cyc(); end
    p_tick_i = 1'b0; p_start_i = 1'b0;
    cyc();
    checks++;
    if (p_timeout_o !== 1'b1 || elapsed_o !== CNT_W'(3)) begin
      errors++; $display("FAIL busy_start_ignored: got timeout=%b elapsed=%0d expected 1/3", p_timeout_o, elapsed_o);
    end
    cyc();
    checks++;
    if (n_tx - tx0 != 1) begin
      errors++; $display("FAIL busy_start_txreq: got %0d expected 1", n_tx - tx0);
    end
    last_elapsed = 3;
  endtask

  task automatic test_abort();
    int tx0, d0, t0;
    tx0 = n_tx; d0 = n_done; t0 = n_to;
    timeout_limit_i = CNT_W'(10); retry_max_i = RTY_W'(2);
    p_start_i = 1'b1; cyc(); p_start_i = 1'b0;
    cyc();
    p_SendFinished_i = 1'b1; cyc(); p_SendFinished_i = 1'b0;
    repeat (2) begin p_tick_i = 1'b1; cyc(); end
    p_tick_i = 1'b0;
    p_abort_i = 1'b1; cyc(); p_abort_i = 1'b0;
    checks++;
    if (busy_o !== 1'b0 || retry_cnt_o !== '0 || elapsed_o !== CNT_W'(last_elapsed)) begin
      errors++; $display("FAIL abort_state: got busy=%b retry=%0d elapsed=%0d expected 0/0/%0d",
                         busy_o, retry_cnt_o, elapsed_o, last_elapsed);
    end
    repeat (15) begin p_tick_i = 1'b1; cyc(); end
    p_tick_i = 1'b0;
    checks++;
    if (n_tx - tx0 != 1 || n_done != d0 || n_to != t0) begin
      errors++; $display("FAIL abort_pulses: got tx=%0d done=%0d to=%0d expected 1/0/0",
                         n_tx - tx0, n_done - d0, n_to - t0);
    end
    p_start_i = 1'b1; p_abort_i = 1'b1; cyc();
    p_start_i = 1'b0; p_abort_i = 1'b0;
    checks++;
    if (busy_o !== 1'b0 || p_tx_req_o !== 1'b0) begin
      errors++; $display("FAIL abort_start_same: got busy=%b tx=%b expected 0/0", busy_o, p_tx_req_o);
    end
  endtask

  task automatic test_saturation();
    int  n;
    bit  seen;
    n = 0; seen = 1'b0;
    timeout_limit_i = '1; retry_max_i = '0;
    p_start_i = 1'b1; cyc(); p_start_i = 1'b0;
    cyc();
    p_SendFinished_i = 1'b1; cyc(); p_SendFinished_i = 1'b0;
    p_tick_i = 1'b1;
    while (!seen && n < 70000) begin
      cyc();
      n++;
      if (p_timeout_o === 1'b1) seen = 1'b1;
    end
    p_tick_i = 1'b0;
    checks++;
    if (!seen || n != 65536) begin
      errors++; $display("FAIL sat_timeout: got seen=%b cycles=%0d expected 1/65536", seen, n);
    end
    checks++;
    if (elapsed_o !== 16'hFFFF) begin
      errors++; $display("FAIL sat_elapsed: got %h expected ffff", elapsed_o);
    end
    cyc();
  endtask

  task automatic test_reset_mid();
    int tx0;
    timeout_limit_i = CNT_W'(5); retry_max_i = RTY_W'(3);
    p_start_i = 1'b1; cyc(); p_start_i = 1'b0;
    cyc();
    p_DataReceived_i = 1'b1; cyc(); p_DataReceived_i = 1'b0;
    checks++;
    if (busy_o !== 1'b1 || p_done_o !== 1'b0) begin
      errors++; $display("FAIL rx_in_wait_tx: got busy=%b done=%b expected 1/0", busy_o, p_done_o);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({p_tx_req_o, busy_o, p_done_o, p_timeout_o} !== 4'b0000 || retry_cnt_o !== '0 || elapsed_o !== '0) begin
      errors++; $display("FAIL reset_mid: got flags=%b retry=%0d elapsed=%0d expected 0000/0/0",
                         {p_tx_req_o, busy_o, p_done_o, p_timeout_o}, retry_cnt_o, elapsed_o);
    end
    repeat (2) cyc();
    rst = 1'b1;
    tx0 = n_tx;
    p_SendFinished_i = 1'b1; cyc(); p_SendFinished_i = 1'b0;
    repeat (10) cyc();
    checks++;
    if (n_tx != tx0 || busy_o !== 1'b0) begin
      errors++; $display("FAIL post_reset_idle: got tx=%0d busy=%b expected 0/0", n_tx - tx0, busy_o);
    end
    last_elapsed = 0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_start_while_busy();
    test_abort();
    test_random();
    test_reset_mid();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
